ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//  Read-side initiator for the single-port synchronous RAM. It has a 1-cycle registered read
//  and is write-first. On start it scans a window of RAM words from base_addr, counting
//  length words, and delivers them in address order on a valid/ready stream.
//  Sits between the display/character buffer RAM and downstream consumers (VGA text, LED/segment drivers).
// PARAMETERS
//  WIDTH  8  RAM data width (bits)
//  DEPTH  3  RAM address width; RAM holds 2**DEPTH words
// PORTS
//  clk        in   1        system clock, all logic on posedge
//  rst        in   1        synchronous, active-high reset
//  start      in   1        begin a scan; sampled only in IDLE
//  base_addr  in   DEPTH    first address of scan; captured on accepted start
//  length     in   DEPTH+1  words to read (0..2**DEPTH); captured on accepted start
//  busy       out  1        high from accepted start until done pulse inclusive
//  done       out  1        1-cycle pulse, cycle after final word handshake
//  ram_ena    out  1        RAM enable; high only in cycles issuing a read
//  wena       out  1        tied 0 (reader never writes)
//  addr       out  DEPTH    RAM address, valid when ram_ena=1
//  ram_dout   in   WIDTH    RAM data_out; valid the cycle after ram_ena=1
//  m_data     out  WIDTH    stream data
//  m_valid    out  1        stream valid
//  m_ready    in   1        stream ready; transfer when m_valid&&m_ready
//  m_last     out  1        high with final word of a pass (qualified by m_valid)
// BEHAVIOUR
//  - Reset: busy=0, done=0, ram_ena=0, addr=0, m_valid=0, m_last=0, m_data=0. FSM->IDLE.
//    Buffer, in-flight flag and counters cleared. Reset mid-scan aborts it; no done pulse.
//  - FSM: IDLE -(start)-> SCAN -(all issued)-> DRAIN -(buffer empty, last accepted)-> DONE -> IDLE.
//    IDLE -(start, length==0)-> DONE directly: no RAM access, done pulses next cycle.
//  - start while not IDLE: ignored, no effect on captured base/length.
//  - Read issue: ram_ena=1 with addr=next address when remaining>0 and (occupancy + inflight - pop) < 2.
//    occupancy = 2-entry output FIFO count; inflight = read issued last cycle;
//    pop = m_valid&&m_ready this cycle.
//  - Read data: captured from ram_dout into FIFO in the cycle after issue, unconditionally (space guaranteed).
//  - Throughput: 1 word/cycle with m_ready held high. First m_valid 2 cycles after accepted start.
//  - Backpressure: m_data/m_valid/m_last stable while m_valid && !m_ready. No word dropped or duplicated.
//  - Address: addr increments mod 2**DEPTH (7 -> 0 wraps for DEPTH=3). length==2**DEPTH reads every word once.
//  - m_last: set on the word whose index == length-1.
//  - done: asserted cycle after last handshake; busy falls with done (busy=1 during the done cycle).
// CONFIGURATION
//  SCAN_LOOP_EN defined:
//   - After final address of a pass, issue restarts at base_addr with no bubble; FSM never leaves SCAN.
//   - m_last marks each pass end; done pulses once per pass (cycle after the m_last handshake).
//   - busy stays high; scan ends only on rst. Continuous refresh for display.
//  SCAN_LOOP_EN undefined: single pass as above.
// TESTING (bench: 8x8 write-first RAM model, ram[k]=0x10+k, WIDTH=8, DEPTH=3)
//  1. start, base=2, length=4, m_ready=1 -> m_data 0x12,0x13,0x14,0x15 on consecutive cycles;
//     m_last with 0x15; done 1 cycle later.
//  2. base=6, length=4 -> addr 6,7,0,1; data 0x16,0x17,0x10,0x11 (wrap).
//  3. base=0, length=8, m_ready toggling 1,0,0,1... -> all 0x10..0x17 in order, each exactly once;
//     data held stable while stalled; at most 2 buffered words.
//  4. length=0 -> no ram_ena, m_valid=0 throughout; done pulse cycle after start; busy high that 1 cycle.
//  5. rst asserted mid-scan after 2 words -> next cycle all outputs at reset values, no done.
//     A fresh start then reads from the new base.
//  6. SCAN_LOOP_EN, base=5, length=3 -> 0x15,0x16,0x17,0x15,... repeating; m_last/done every 3rd word.

Source files
------------

// File: rtl/ram_stream_reader_if.sv
// RAM read bus and output stream grouped for ram_stream_reader.
// The master side is the reader. The slave side is the RAM plus the downstream consumer.
interface ram_stream_reader_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
);
  logic             ram_ena;
  logic             wena;
  logic [DEPTH-1:0] addr;
  logic [WIDTH-1:0] ram_dout;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output ram_ena, wena, addr, m_data, m_valid, m_last,
    input  ram_dout, m_ready
  );

  modport slave (
    input  ram_ena, wena, addr, m_data, m_valid, m_last,
    output ram_dout, m_ready
  );
endinterface

// File: rtl/ram_stream_reader.sv
// Scans a window of a 1-cycle-latency RAM and streams the words out over valid/ready.
// Define SCAN_LOOP_EN to make the scan repeat forever, for continuous display refresh.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing reads (loop build stays here until reset)
// DRAIN | all reads issued, emptying the output buffer
// DONE  | one-cycle done pulse, busy still high
module ram_stream_reader #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DEPTH-1:0]  base_addr,
  input  logic [DEPTH:0]    length,
  output logic              busy,
  output logic              done,
  ram_stream_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t           state;
  logic [DEPTH-1:0] addr_q;
  logic [DEPTH:0]   remaining;
  logic             inflight;
  logic             inflight_last;
  logic [WIDTH-1:0] fifo_data [2];
  logic [1:0]       fifo_last;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             pop;
  logic             issue;
  logic [2:0]       occ_after;
`ifdef SCAN_LOOP_EN
  logic [DEPTH-1:0] base_q;
  logic [DEPTH:0]   len_q;
`endif

  assign pop       = (count != 2'd0) && bus.m_ready;
  // A read is issued only if its data is sure to find a free buffer slot.
  assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == SCAN) && (remaining != '0) && (occ_after < 3'd2);

  assign bus.ram_ena = issue;
  assign bus.wena    = 1'b0;
  assign bus.addr    = addr_q;
  assign bus.m_valid = (count != 2'd0);
  assign bus.m_data  = fifo_data[rd_ptr];
  assign bus.m_last  = (count != 2'd0) && fifo_last[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      addr_q        <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      fifo_data[0]  <= '0;
      fifo_data[1]  <= '0;
      fifo_last     <= 2'b00;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
`ifdef SCAN_LOOP_EN
      base_q        <= '0;
      len_q         <= '0;
`endif
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue && (remaining == (DEPTH+1)'(1));
      if (inflight) begin
        fifo_data[wr_ptr] <= bus.ram_dout;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};

      case (state)
        IDLE: begin
          if (start) begin
            addr_q    <= base_addr;
            remaining <= length;
            busy      <= 1'b1;
`ifdef SCAN_LOOP_EN
            base_q    <= base_addr;
            len_q     <= length;
`endif
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (issue) begin
            if (remaining == (DEPTH+1)'(1)) begin
`ifdef SCAN_LOOP_EN
              addr_q    <= base_q;
              remaining <= len_q;
`else
              addr_q    <= addr_q + DEPTH'(1);
              remaining <= '0;
              state     <= DRAIN;
`endif
            end else begin
              addr_q    <= addr_q + DEPTH'(1);
              remaining <= remaining - (DEPTH+1)'(1);
            end
          end
`ifdef SCAN_LOOP_EN
          if (pop && bus.m_last)
            done <= 1'b1;
`endif
        end
        DRAIN: begin
          if (pop && bus.m_last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed, scoreboard-based bench for ram_stream_reader against an 8x8 RAM model holding 0x10+k.
// The SCAN_LOOP_EN build runs the repeating-scan scenario in place of the single-pass ones.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] base_addr;
  logic [3:0] length;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  logic [8:0] sb [$];
  logic [7:0] ram [8];

  ram_stream_reader_if #(.WIDTH(8), .DEPTH(3)) bus ();

  ram_stream_reader #(.WIDTH(8), .DEPTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_ena) begin
      if (bus.wena) bus.ram_dout <= 8'h00;
      else          bus.ram_dout <= ram[bus.addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input int mode, input int c);
    if (mode == 0) return 1'b1;
    return (c % 3) == 0;
  endfunction

  task automatic run_scan(input int b, input int l, input int mode, input int abort_after,
                          input int loop_passes, input bit ign_start, input bit chk_timing);
    int hs, iss, first_v, last_hs, dones, exp_addr, nwords;
    bit fin, stall;
    logic [7:0] pdata;
    logic plast;
    logic [8:0] e;
    sb.delete();
    nwords = (loop_passes > 0) ? loop_passes * l : l;
    for (int i = 0; i < nwords; i++)
      sb.push_back({((i % l) == l - 1) ? 1'b1 : 1'b0, 8'h10 + 8'((b + (i % l)) % 8)});
    hs = 0; iss = 0; first_v = -1; last_hs = 0; dones = 0; fin = 0; stall = 0;
    pdata = '0; plast = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 3'(b); length = 4'(l); bus.m_ready = rdy(mode, 0);
    for (int c = 1; c < 300 && !fin; c++) begin
      @(negedge clk);
      start = ign_start && (c == 2);
      if (start) begin base_addr = 3'd0; length = 4'd1; end
      bus.m_ready = rdy(mode, c);
      #1;
      if (stall) begin
        chk("hold_data", bus.m_data, pdata);
        chk("hold_valid", bus.m_valid, 1);
        chk("hold_last", bus.m_last, plast);
      end
      if (bus.ram_ena) begin
        exp_addr = (b + (iss % l)) % 8;
        chk("addr", bus.addr, exp_addr);
        iss++;
      end
      if (bus.m_valid && first_v < 0) first_v = c;
      if (bus.m_valid && bus.m_ready) begin
        if (sb.size() == 0) chk("extra_word", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("data", bus.m_data, e[7:0]);
          chk("last", bus.m_last, e[8]);
        end
        hs++;
        if (bus.m_last) last_hs = c;
      end
      chk("buffer_bound", (iss - hs) <= 2, 1);
      if (l == 0) begin
        chk("len0_no_ena", bus.ram_ena, 0);
        chk("len0_no_valid", bus.m_valid, 0);
      end
      if (done) begin
        dones++;
        chk("done_after_last", c, last_hs + 1);
        chk("busy_with_done", busy, 1);
        if (loop_passes == 0) begin
          chk("sb_empty", sb.size(), 0);
          fin = 1;
        end else if (dones == loop_passes) begin
          fin = 1;
        end
      end
      if (abort_after > 0 && hs == abort_after) fin = 1;
      stall = bus.m_valid && !bus.m_ready;
      pdata = bus.m_data;
      plast = bus.m_last;
    end
    chk("no_timeout", fin, 1);
    if (chk_timing) begin
      chk("first_valid", first_v, 3);
      chk("last_hs_cycle", last_hs, 2 + l);
    end
    if (loop_passes == 0 && abort_after == 0) begin
      @(negedge clk);
      #1;
      chk("busy_fall", busy, 0);
      chk("done_pulse_1cyc", done, 0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ram_ena"}, bus.ram_ena, 0);
    chk({tag, "_addr"}, bus.addr, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_wena"}, bus.wena, 0);
  endtask

  initial begin
    for (int k = 0; k < 8; k++) ram[k] = 8'h10 + 8'(k);
    rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

`ifdef SCAN_LOOP_EN
    run_scan(5, 3, 0, 0, 4, 1'b0, 1'b0);
    chk("loop_busy_held", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("loop_abort");
    rst = 1'b0;
`else
    run_scan(2, 4, 0, 0, 0, 1'b0, 1'b1);
    run_scan(6, 4, 0, 0, 0, 1'b1, 1'b1);
    run_scan(0, 8, 1, 0, 0, 1'b0, 1'b0);
    run_scan(0, 0, 0, 0, 0, 1'b0, 1'b0);
    run_scan(5, 8, 0, 0, 0, 1'b0, 1'b1);
    run_scan(1, 6, 0, 2, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("abort");
    rst = 1'b0;
    run_scan(4, 3, 0, 0, 0, 1'b0, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
